uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding a start/data/parity/stop serializer.
// Frame configuration is captured when each frame starts.
module uart_tx_engine #(
  parameter int p_fifo_depth = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  input  logic        i_tx_en,
  input  logic [15:0] i_baudrate,
  input  logic        i_parity,
  input  logic        i_nb_stop_bits,
  output logic        o_tx_full,
  output logic        o_tx_empty,
  output logic        o_tx_busy,
  output logic        o_tx
);

  localparam int AW = (p_fifo_depth > 1) ? $clog2(p_fifo_depth) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    mem_q [p_fifo_depth];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic        par_en_q, par_en_d;
  logic        stop2_q, stop2_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        can_start;
  logic        load;

  assign o_tx_full  = (cnt_q == CW'(p_fifo_depth));
  assign o_tx_empty = (cnt_q == '0);
  assign o_tx_busy  = (state_q != IDLE);
  assign o_tx       = tx_q;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign push      = i_data_valid & ~o_tx_full;
  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (baud_cnt_q == 16'd0);
  assign can_start = i_tx_en & ~o_tx_empty;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_d      = bit_q;
    baud_d     = baud_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
    baud_cnt_d = bit_end ? baud_q : baud_cnt_q - 16'd1;
    load       = 1'b0;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        load       = can_start;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_q : 1'b1;
            bit_d   = '0;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else if (can_start) begin
            load = 1'b1;
          end else begin
            state_d    = IDLE;
            tx_d       = 1'b1;
            bit_d      = '0;
            baud_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the head byte and capture this frame's configuration.
    if (load) begin
      pop        = 1'b1;
      state_d    = START;
      tx_d       = 1'b0;
      shift_d    = head;
      par_d      = ^head;
      bit_d      = '0;
      baud_d     = i_baudrate;
      baud_cnt_d = i_baudrate;
      par_en_d   = i_parity;
      stop2_d    = i_nb_stop_bits;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_q      <= '0;
      baud_cnt_q <= '0;
      baud_q     <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_q      <= bit_d;
      baud_cnt_q <= baud_cnt_d;
      baud_q     <= baud_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: queued bytes are matched against
// serial frames rebuilt from the line, cycle by cycle.
module tb_uart_tx_engine;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        data_valid;
  logic        tx_en;
  logic [15:0] baud;
  logic        par;
  logic        stop2;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_busy;
  logic        tx;

  uart_tx_engine #(.p_fifo_depth(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_data         (data),
    .i_data_valid   (data_valid),
    .i_tx_en        (tx_en),
    .i_baudrate     (baud),
    .i_parity       (par),
    .i_nb_stop_bits (stop2),
    .o_tx_full      (tx_full),
    .o_tx_empty     (tx_empty),
    .o_tx_busy      (tx_busy),
    .o_tx           (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int frames = 0;

  logic [7:0] q[$];

  bit in_frame = 1'b0;
  int idx = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: expected line behaviour derived from queued bytes and the
  // configuration seen on the inputs just before each frame begins.
  initial begin
    bit p_rst = 1'b1;
    bit p_en = 1'b0;
    bit p_qn = 1'b0;
    int p_baud = 0;
    bit p_par = 1'b0;
    bit p_stop = 1'b0;
    bit exp_s;
    bit bits[12];
    int nb = 10;
    int per = 1;
    int cyc = 0;
    bit err = 1'b0;
    int bad_idx = 0;
    logic [7:0] cur = '0;

    @(posedge clk);
    forever begin
      @(negedge clk);
      if (p_rst) begin
        in_frame = 1'b0;
        chk(tx === 1'b1 && tx_busy === 1'b0 && tx_empty === 1'b1 &&
            tx_full === 1'b0, "reset_state",
            {tx, tx_busy, tx_empty, tx_full}, 4'b1010);
      end else begin
        if (!in_frame) begin
          exp_s = p_en && p_qn;
          chk(tx === !exp_s && tx_busy === exp_s, "idle_or_start",
              {tx, tx_busy}, {!exp_s, exp_s});
          if (exp_s && tx === 1'b0) begin
            cur = q.pop_front();
            bits[0] = 1'b0;
            for (int k = 0; k < 8; k++) bits[k+1] = cur[k];
            nb = 9;
            if (p_par) begin
              bits[nb] = ^cur;
              nb++;
            end
            bits[nb] = 1'b1;
            nb++;
            if (p_stop) begin
              bits[nb] = 1'b1;
              nb++;
            end
            per = p_baud + 1;
            in_frame = 1'b1;
            idx = 0;
            cyc = 0;
            err = 1'b0;
          end
        end
        if (in_frame) begin
          if ((tx !== bits[idx] || tx_busy !== 1'b1) && !err) begin
            err = 1'b1;
            bad_idx = idx;
          end
          cyc++;
          if (cyc == per) begin
            cyc = 0;
            idx++;
            if (idx == nb) begin
              in_frame = 1'b0;
              frames++;
              chk(!err, "frame_bits", {24'd0, cur}, bad_idx);
            end
          end
        end
        chk(tx_empty === (q.size() == 0) && tx_full === (q.size() == DEPTH),
            "fifo_flags", {tx_empty, tx_full},
            {q.size() == 0, q.size() == DEPTH});
      end
      p_rst  = rst;
      p_en   = tx_en;
      p_qn   = q.size() > 0;
      p_baud = int'(baud);
      p_par  = par;
      p_stop = stop2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bit acc;
    acc = q.size() < DEPTH;
    data = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    if (acc) q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q.size() != 0 || in_frame) && n < 3000) begin
      tick();
      n++;
    end
    chk(n < 3000, name, n, 3000);
    tick();
    tick();
  endtask

  task automatic wait_data(input string name);
    int n = 0;
    while (!(in_frame && idx >= 3) && n < 500) begin
      tick();
      n++;
    end
    chk(n < 500, name, n, 500);
  endtask

  initial begin
    int f0;
    int r;
    rst = 1'b1;
    data = '0;
    data_valid = 1'b0;
    tx_en = 1'b1;
    baud = 16'd3;
    par = 1'b0;
    stop2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Plain 8N1 frame at 4 clocks per bit.
    f0 = frames;
    push(8'hA5);
    wait_idle("wait_a5");
    chk(frames == f0 + 1, "a5_count", frames - f0, 1);

    // Even parity, two stop bits.
    par = 1'b1;
    stop2 = 1'b1;
    push(8'h07);
    wait_idle("wait_07");
    par = 1'b0;
    stop2 = 1'b0;

    // Fill while disabled, overflow drops the fifth byte.
    tx_en = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk(tx_full === 1'b1, "full_after_4", tx_full, 1);
    push(8'h55);
    chk(tx_full === 1'b1 && q.size() == 4, "drop_5th", {tx_full, 8'(q.size())}, 9'h104);
    chk(tx === 1'b1 && tx_busy === 1'b0, "hold_disabled", {tx, tx_busy}, 2'b10);
    f0 = frames;
    tx_en = 1'b1;
    wait_idle("wait_burst");
    chk(frames == f0 + 4, "burst_count", frames - f0, 4);
    chk(tx_empty === 1'b1 && tx_busy === 1'b0, "burst_done",
        {tx_empty, tx_busy}, 2'b10);

    // One clock per bit, back to back.
    baud = 16'd0;
    push(8'hFF);
    push(8'h00);
    wait_idle("wait_fast");

    // Config change and disable mid-frame.
    baud = 16'd3;
    push(8'hC3);
    push(8'h3C);
    wait_data("wait_c3_data");
    baud = 16'd7;
    tx_en = 1'b0;
    repeat (60) tick();
    chk(q.size() == 1 && tx === 1'b1 && tx_busy === 1'b0, "3c_held",
        {8'(q.size()), tx, tx_busy}, 10'h006);
    tx_en = 1'b1;
    wait_idle("wait_3c");
    baud = 16'd3;

    // Reset mid-frame with bytes still queued; pushes in reset ignored.
    push(8'h81);
    push(8'h42);
    push(8'h24);
    wait_data("wait_rst_data");
    data = 8'h99;
    data_valid = 1'b1;
    do_reset();
    data_valid = 1'b0;
    f0 = frames;
    repeat (30) tick();
    chk(frames == f0 && tx_empty === 1'b1, "no_frames_after_rst",
        {frames - f0, 1'b0, tx_empty}, 1);

    // Randomized traffic with random config.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 11);
      if (r < 3 && q.size() < DEPTH) push(8'($urandom));
      else if (r == 3) baud = 16'($urandom_range(0, 3));
      else if (r == 4) par = 1'($urandom);
      else if (r == 5) stop2 = 1'($urandom);
      else if (r == 6) tx_en = ($urandom_range(0, 3) != 0);
      else tick();
    end
    tx_en = 1'b1;
    wait_idle("wait_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
